// File: rtl/protocore_pkg.sv
// Shared ISA definitions for the protocore controller: opcode classes,
// ALU op codes, FSM state encoding, decoded-instruction struct and field slices.
package protocore_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // Opcode classes in ir[15:12] when ir[15]=1 (0xC-0xE decode as NOP)
  localparam logic [3:0] CLS_LDI  = 4'h8;
  localparam logic [3:0] CLS_JMP  = 4'h9;
  localparam logic [3:0] CLS_BZ   = 4'hA;
  localparam logic [3:0] CLS_BC   = 4'hB;
  localparam logic [3:0] CLS_HALT = 4'hF;

  // ALU op codes (meaning lives in the datapath; passed through untouched)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_MOV = 3'd7;

  typedef struct packed {
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_bz;
    logic       is_bc;
    logic       is_halt;
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm;
  } decode_t;

  // Instruction field slices
  function automatic logic [3:0] ir_cls(input logic [15:0] ir); return ir[15:12]; endfunction
  function automatic logic [2:0] ir_op (input logic [15:0] ir); return ir[14:12]; endfunction
  function automatic logic [3:0] ir_rd (input logic [15:0] ir); return ir[11:8];  endfunction
  function automatic logic [3:0] ir_ra (input logic [15:0] ir); return ir[7:4];   endfunction
  function automatic logic [3:0] ir_rb (input logic [15:0] ir); return ir[3:0];   endfunction
  function automatic logic [7:0] ir_imm(input logic [15:0] ir); return ir[7:0];   endfunction

endpackage

// File: rtl/protocore_decode.sv
// Combinational instruction decoder: ir -> class flags and operand fields.
module protocore_decode
  import protocore_pkg::*;
(
  input  logic [15:0] ir,
  output decode_t     dec
);

  // Classify the instruction; ALU op is forced to 0 for non-ALU classes
  always_comb begin
    dec     = '0;
    dec.rd  = ir_rd(ir);
    dec.ra  = ir_ra(ir);
    dec.rb  = ir_rb(ir);
    dec.imm = ir_imm(ir);
    if (!ir[15]) begin
      dec.is_alu = 1'b1;
      dec.op     = ir_op(ir);
    end else begin
      case (ir_cls(ir))
        CLS_LDI:  dec.is_ldi  = 1'b1;
        CLS_JMP:  dec.is_jmp  = 1'b1;
        CLS_BZ:   dec.is_bz   = 1'b1;
        CLS_BC:   dec.is_bc   = 1'b1;
        CLS_HALT: dec.is_halt = 1'b1;
        default:  ;  // 0xC-0xE: NOP
      endcase
    end
  end

endmodule

// File: rtl/protocore_control.sv
// Fetch/decode/execute controller for the 8-bit datapath. Holds the FSM,
// pc, instruction register and zero/carry flags.
module protocore_control
  import protocore_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [15:0]        imem_rdata,
  output logic [2:0]         alu_opcode,
  output logic [RADDR_W-1:0] ra_addr,
  output logic [RADDR_W-1:0] rb_addr,
  output logic [RADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]  write_data,
  output logic               write_en,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  output logic               halted
);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            zf, cf;
  decode_t         dec;
  logic            br_taken;

  protocore_decode u_dec (.ir(ir), .dec(dec));

  assign br_taken = dec.is_jmp || (dec.is_bz && zf) || (dec.is_bc && cf);

  // FSM, pc, ir and flags; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (dec.is_alu || dec.is_ldi) begin
            state <= ST_WB;
          end else if (dec.is_halt) begin
            state <= ST_HALT;
          end else begin
            pc    <= br_taken ? PC_W'(dec.imm) : pc + 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_WB: begin
          if (dec.is_alu) begin
            zf <= alu_zero;
            cf <= alu_carry;
          end
          pc    <= pc + 1'b1;
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath and fetch outputs decoded from state; operands held through EXEC and WB
  always_comb begin
    imem_req   = (state == ST_FETCH);
    imem_addr  = pc;
    halted     = (state == ST_HALT);
    alu_opcode = '0;
    ra_addr    = '0;
    rb_addr    = '0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    if (state == ST_EXEC || state == ST_WB) begin
      alu_opcode = dec.op;
      ra_addr    = RADDR_W'(dec.ra);
      rb_addr    = RADDR_W'(dec.rb);
    end
    if (state == ST_WB) begin
      write_en   = 1'b1;
      write_addr = RADDR_W'(dec.rd);
      write_data = dec.is_ldi ? DATA_W'(dec.imm) : alu_result;
    end
  end

endmodule

// File: tb/tb_protocore_control.sv
// Self-checking bench for protocore_control: a directed program, a reset-abort
// scenario and a randomized run, all checked every cycle against an
// instruction-level reference model.
module tb_protocore_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [2:0]  alu_opcode;
  logic [3:0]  ra_addr, rb_addr, write_addr;
  logic [7:0]  write_data;
  logic        write_en;
  logic [7:0]  alu_result = '0;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        halted;

  always #5 clk = ~clk;

  protocore_control dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .halted(halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [256];

  // Reference model: architectural state plus how many cycles of the
  // current instruction remain after it was fetched.
  logic [7:0]  m_pc;
  logic        m_zf, m_cf, m_halted;
  int          m_phase;  // 0: post-reset idle cycle, 1: fetching, 2: executing
  logic [15:0] m_ir;
  int          m_left;

  int mode;  // 0 directed, 1 reset abort, 2 random
  int hold_cnt = 0;
  int n_fetch  = 0;
  int ab_writes = 0;
  bit aborted = 0;
  logic [7:0]  fq [$];
  logic [11:0] wq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input logic [15:0] ir);
    return !ir[15] || ir[15:12] == 4'h8;
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_zf = 0; m_cf = 0; m_halted = 0;
    m_phase = 0; m_ir = 16'h0000; m_left = 0;
  endtask

  // Architectural effect of an instruction once its last cycle completes
  task automatic retire();
    logic [3:0] cls;
    cls = m_ir[15:12];
    m_phase = 1;
    if (cls == 4'hF) m_halted = 1;
    else if (!m_ir[15]) begin
      m_zf = alu_zero; m_cf = alu_carry; m_pc = m_pc + 8'd1;
    end
    else if (cls == 4'h9) m_pc = m_ir[7:0];
    else if (cls == 4'hA) m_pc = m_zf ? m_ir[7:0] : m_pc + 8'd1;
    else if (cls == 4'hB) m_pc = m_cf ? m_ir[7:0] : m_pc + 8'd1;
    else m_pc = m_pc + 8'd1;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else if (m_halted) ;
    else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      if (imem_valid) begin
        m_ir = imem_rdata; m_phase = 2; m_left = writes(m_ir) ? 2 : 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) retire();
    end
  endtask

  function automatic logic [33:0] model_outputs();
    logic req, we, h;
    logic [2:0] op;
    logic [3:0] ra, rb, wa;
    logic [7:0] wd;
    req = 0; we = 0; h = 0; op = 0; ra = 0; rb = 0; wa = 0; wd = 0;
    if (m_halted) h = 1;
    else if (m_phase == 1) req = 1;
    else if (m_phase == 2) begin
      if (!m_ir[15]) op = m_ir[14:12];
      ra = m_ir[7:4]; rb = m_ir[3:0];
      if (m_left == 1 && writes(m_ir)) begin
        we = 1; wa = m_ir[11:8];
        wd = (m_ir[15:12] == 4'h8) ? m_ir[7:0] : alu_result;
      end
    end
    return {req, m_pc, op, ra, rb, wa, wd, we, h};
  endfunction

  // One clock: compare outputs, pick the inputs for the next edge, advance model
  task automatic step(input bit rst_in);
    bit fetching;
    @(negedge clk);
    check("outputs", {imem_req, imem_addr, alu_opcode, ra_addr, rb_addr,
                      write_addr, write_data, write_en, halted}, model_outputs());
    if (write_en) begin
      if (mode == 0) wq.push_back({write_addr, write_data});
      if (mode == 1) ab_writes++;
    end
    rst_n = rst_in;
    if (mode == 1 && m_phase == 2 && m_left == 2 && m_ir == 16'h835A) begin
      rst_n = 0; aborted = 1;
    end
    if (mode == 2 && $urandom_range(0, 149) == 0) rst_n = 0;
    fetching = !m_halted && m_phase == 1;
    if (mode == 0) begin
      if (fetching && m_pc == 8'h00 && n_fetch > 0 && hold_cnt < 4) begin
        imem_valid = 0; hold_cnt++;
      end else imem_valid = 1;
    end else if (mode == 1) imem_valid = 1;
    else imem_valid = ($urandom_range(0, 3) != 0);
    imem_rdata = imem_valid ? mem[imem_addr] : 16'($urandom);
    if (mode == 0 && fetching && imem_valid && rst_n) begin
      fq.push_back(imem_addr);
      n_fetch++;
      if (n_fetch == 1) mem[0] = 16'hF000;
    end
    if (mode == 2) begin
      alu_result = 8'($urandom); alu_zero = 1'($urandom); alu_carry = 1'($urandom);
    end else begin
      alu_zero   = (m_ir == 16'h0123);
      alu_carry  = (m_ir == 16'h0123);
      alu_result = (m_ir == 16'h0123) ? 8'h00 : 8'h77;
    end
    model_step();
  endtask

  function automatic logic [15:0] rand_insn();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45)      return {1'b0, 15'($urandom)};
    else if (r < 60) return {4'h8, 12'($urandom)};
    else if (r < 70) return {4'h9, 4'($urandom), 8'($urandom)};
    else if (r < 78) return {4'hA, 4'($urandom), 8'($urandom)};
    else if (r < 86) return {4'hB, 4'($urandom), 8'($urandom)};
    else if (r < 95) return {4'($urandom_range(12, 14)), 12'($urandom)};
    else             return 16'hF000;
  endfunction

  initial begin
    logic [7:0]  exp_f [8];
    logic [11:0] exp_w [4];
    int k;
    exp_f = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'hFF, 8'h00};
    exp_w = '{12'h35A, 12'h100, 12'h477, 12'h777};
    model_reset();

    // Directed program
    mode = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
    mem[8'h00] = 16'h835A;  // LDI r3,0x5A
    mem[8'h01] = 16'h0123;  // ADD r1,r2,r3 -> 0, zf=cf=1
    mem[8'h02] = 16'hA010;  // BZ 0x10 (taken)
    mem[8'h10] = 16'h0456;  // ADD r4 -> 0x77, zf=cf=0
    mem[8'h11] = 16'hB020;  // BC 0x20 (not taken)
    mem[8'h12] = 16'h90FF;  // JMP 0xFF
    mem[8'hFF] = 16'h1789;  // SUB r7 -> pc wraps to 0 (then HALT there)
    for (int i = 0; i < 3; i++) step(0);
    check("reset_outputs", {imem_req, imem_addr, alu_opcode, ra_addr, rb_addr,
                            write_addr, write_data, write_en, halted}, 34'h0);
    step(1);
    check("idle_no_req", imem_req, 1'b0);
    step(1);
    check("first_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
    k = 0;
    while (!halted && k < 200) begin step(1); k++; end
    check("halt_reached", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("halt_hold", {halted, imem_req, write_en}, 3'b100);
    end
    check("fetch_count", fq.size(), 8);
    for (int i = 0; i < 8 && i < fq.size(); i++) check("fetch_addr", fq[i], exp_f[i]);
    check("write_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) check("write_rd_data", wq[i], exp_w[i]);
    check("imem_wait_cycles", hold_cnt, 4);

    // Reset during EXEC of an LDI
    mode = 1;
    step(0);
    mem[0] = 16'h835A;
    k = 0;
    while (!aborted && k < 20) begin step(1); k++; end
    check("abort_fired", aborted, 1'b1);
    step(1);
    check("abort_no_write", ab_writes, 0);
    check("abort_pc", {imem_addr, imem_req, halted}, 10'h000);

    // Randomized run
    mode = 2;
    for (int i = 0; i < 256; i++) mem[i] = rand_insn();
    step(0);
    step(0);
    for (int i = 0; i < 4000; i++) step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
